cn_key_expansion: RTL and testbench



---
 rtl/cn_aes_pkg.sv | 41 ++++
 rtl/aes_sbox.sv | 97 +++++++++
 rtl/cn_key_expansion.sv | 80 ++++++++
 tb/tb_cn_key_expansion.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cn_aes_pkg.sv
// Shared AES helpers for the CryptoNight key schedule: S-box table, word
// helpers and run command encodings.
package cn_aes_pkg;

  localparam logic [1:0] RUN_HOLD  = 2'd0;
  localparam logic [1:0] RUN_LOAD0 = 2'd1;
  localparam logic [1:0] RUN_LOAD1 = 2'd2;
  localparam logic [1:0] RUN_ITER  = 2'd3;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational. CN_KEYEXP_SBOX_GF_EN selects composite-field
// GF((2^4)^2) inversion + affine; otherwise a 256-entry table lookup.
module aes_sbox
  import cn_aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

`ifdef CN_KEYEXP_SBOX_GF_EN
  // GF(16) with x^4+x+1; GF(256) as GF(16)[y]/(y^2+y+LAMBDA), trace(LAMBDA)=1.
  localparam logic [3:0] LAMBDA = 4'h8;

  function automatic logic [3:0] g16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] s;
    r = 4'h0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] g16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = g16_mul(a, a);
    a4 = g16_mul(a2, a2);
    a8 = g16_mul(a4, a4);
    return g16_mul(g16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = g16_mul(a[7:4], b[7:4]);
    return {hh ^ g16_mul(a[7:4], b[3:0]) ^ g16_mul(a[3:0], b[7:4]),
            g16_mul(hh, LAMBDA) ^ g16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] c_inv(input logic [7:0] a);
    logic [3:0] h, l, di;
    h  = a[7:4];
    l  = a[3:0];
    di = g16_inv(g16_mul(g16_mul(h, h), LAMBDA) ^ g16_mul(h, l) ^ g16_mul(l, l));
    return {g16_mul(h, di), g16_mul(h ^ l, di)};
  endfunction

  function automatic logic [7:0] map8(input logic [7:0][7:0] cols, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) if (x[i]) r = r ^ cols[i];
    return r;
  endfunction

  // Images of the AES polynomial basis: powers of a root of x^8+x^4+x^3+x+1.
  function automatic logic [7:0][7:0] fwd_cols();
    logic [7:0][7:0] cols;
    logic [7:0] beta, c, c2, c3, c4, c8;
    beta = 8'h00;
    for (int k = 255; k > 0; k--) begin
      c  = k[7:0];
      c2 = c_mul(c, c);
      c3 = c_mul(c2, c);
      c4 = c_mul(c2, c2);
      c8 = c_mul(c4, c4);
      if ((c8 ^ c4 ^ c3 ^ c ^ 8'h01) == 8'h00) beta = c;
    end
    cols[0] = 8'h01;
    for (int i = 1; i < 8; i++) cols[i] = c_mul(cols[i-1], beta);
    return cols;
  endfunction

  function automatic logic [7:0][7:0] inv_cols(input logic [7:0][7:0] fwd);
    logic [7:0][7:0] cols;
    cols = '0;
    for (int j = 0; j < 8; j++)
      for (int a = 0; a < 256; a++)
        if (map8(fwd, a[7:0]) == (8'h01 << j)) cols[j] = a[7:0];
    return cols;
  endfunction

  localparam logic [7:0][7:0] FWD = fwd_cols();
  localparam logic [7:0][7:0] INV = inv_cols(FWD);

  logic [7:0] inv_poly;
  always_comb begin
    inv_poly = map8(INV, c_inv(map8(FWD, din)));
    for (int i = 0; i < 8; i++)
      dout[i] = inv_poly[i] ^ inv_poly[(i+4)%8] ^ inv_poly[(i+5)%8] ^
                inv_poly[(i+6)%8] ^ inv_poly[(i+7)%8] ^ 8'h63 >> i;
  end
`else
  assign dout = SBOX[din];
`endif

endmodule

// File: rtl/cn_key_expansion.sv
// Iterative AES-256 key schedule: one 128-bit round key per iterate cycle.
// S-box flavour chosen in aes_sbox via CN_KEYEXP_SBOX_GF_EN.
module cn_key_expansion
  import cn_aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   run,
  input  logic [127:0] Cipherkey,
  output logic [127:0] Roundkeys
);

  logic [127:0]     k0_q, k0_d, k1_q, k1_d;
  logic             par_q, par_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [31:0]      sub_in, sub_out, t_word;
  logic [3:0][31:0] a_w, n_w;

  // Even keys take RotWord + rcon, odd keys a plain SubWord of K1's last word.
  assign sub_in = par_q ? k1_q[31:0] : rot_word(k1_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sub_in[8*i +: 8]),
      .dout (sub_out[8*i +: 8])
    );
  end

  // a_w[3] is word 0 (msb word); the XOR chain runs toward the lsb word.
  always_comb begin
    t_word = sub_out ^ (par_q ? 32'h0 : {rcon_q, 24'h0});
    a_w    = k0_q;
    n_w    = '0;
    n_w[3] = a_w[3] ^ t_word;
    for (int i = 2; i >= 0; i--) n_w[i] = a_w[i] ^ n_w[i+1];
  end

  always_comb begin
    k0_d   = k0_q;
    k1_d   = k1_q;
    par_d  = par_q;
    rcon_d = rcon_q;
    case (run)
      RUN_LOAD0: begin
        k0_d   = Cipherkey;
        par_d  = 1'b0;
        rcon_d = 8'h01;
      end
      RUN_LOAD1: begin
        k1_d   = Cipherkey;
        par_d  = 1'b0;
        rcon_d = 8'h01;
      end
      RUN_ITER: begin
        k0_d  = k1_q;
        k1_d  = n_w;
        par_d = ~par_q;
        if (!par_q) rcon_d = xtime(rcon_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k0_q   <= '0;
      k1_q   <= '0;
      par_q  <= 1'b0;
      rcon_q <= 8'h01;
    end else begin
      k0_q   <= k0_d;
      k1_q   <= k1_d;
      par_q  <= par_d;
      rcon_q <= rcon_d;
    end
  end

  assign Roundkeys = k0_q;

endmodule

// File: tb/tb_cn_key_expansion.sv
// Directed bench for cn_key_expansion using the FIPS-197 A.3 AES-256 key.
module tb_cn_key_expansion;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   run = 2'd0;
  logic [127:0] Cipherkey = '0;
  logic [127:0] Roundkeys;

  int checks = 0;
  int errors = 0;

  cn_key_expansion dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .Cipherkey (Cipherkey),
    .Roundkeys (Roundkeys)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   run;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [127:0] rk [0:14];
  logic [127:0] half0, half1, zk2, zk3;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] r, input logic [127:0] k, input logic [127:0] e);
    vec_t v;
    v.run = r;
    v.key = k;
    v.exp = e;
    tbl.push_back(v);
  endtask

  // Drive mid-cycle, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic [1:0] r, input logic [127:0] k);
    @(negedge clk);
    run = r;
    Cipherkey = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rk[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
    rk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
    rk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    rk[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    rk[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
    rk[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
    rk[6]  = 128'h812c81addadf48ba24360af2fab8b464;
    rk[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
    rk[8]  = 128'h68007bacb2df331696e939e46c518d80;
    rk[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
    rk[10] = 128'hde1369676ccc5a71fa2563959674ee15;
    rk[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
    rk[12] = 128'h749c47ab18501ddae2757e4f7401905a;
    rk[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
    rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    half0  = rk[0];
    half1  = rk[1];
    zk2    = 128'h62636363626363636263636362636363;
    zk3    = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    // Full schedule to rk14 with two hold cycles after rk3.
    add(2'd1, half0, rk[0]);
    add(2'd2, half1, rk[0]);
    for (int i = 1; i <= 14; i++) begin
      add(2'd3, '0, rk[i]);
      if (i == 3) begin
        add(2'd0, '1, rk[3]);
        add(2'd0, '1, rk[3]);
      end
    end
    // Reload after 5 iterates with an all-zero key.
    add(2'd1, half0, rk[0]);
    add(2'd2, half1, rk[0]);
    for (int i = 1; i <= 5; i++) add(2'd3, '0, rk[i]);
    add(2'd1, '0, '0);
    add(2'd2, '0, '0);
    add(2'd3, '0, '0);
    add(2'd3, '0, zk2);
    // Lone half-0 load mid-schedule leaves K1 (zero-key rk3) intact.
    add(2'd1, half0, half0);
    add(2'd3, '0, zk3);

    // Reset state.
    #1;
    check("reset_async", Roundkeys, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", Roundkeys, '0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2'd0, '1);
    check("reset_idle", Roundkeys, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].run, tbl[i].key);
      check($sformatf("vec%0d", i), Roundkeys, tbl[i].exp);
    end

    // Asynchronous reset mid-iteration, then a clean reload.
    step(2'd1, half0);
    step(2'd2, half1);
    step(2'd3, '0);
    step(2'd3, '0);
    check("pre_reset_rk2", Roundkeys, rk[2]);
    @(negedge clk);
    run = 2'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_zero", Roundkeys, '0);
    @(posedge clk);
    #1;
    check("reset_hold_iter", Roundkeys, '0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2'd1, half0);
    check("reload_half0", Roundkeys, rk[0]);
    step(2'd2, half1);
    check("reload_rk0", Roundkeys, rk[0]);
    for (int i = 1; i <= 3; i++) begin
      step(2'd3, '0);
      check($sformatf("reload_rk%0d", i), Roundkeys, rk[i]);
    end

    step(2'd0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
